// File: rtl/result_to_ascii.sv
// result_to_ascii: sequential double-dabble of a binary result, streamed as ASCII decimal digits MSD-first
module result_to_ascii #(
  parameter int WIDTH = 32,
  parameter int DIGITS = 10,
  parameter bit EMIT_NEWLINE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             char_valid,
  output logic [7:0]       char_data,
  input  logic             char_ready,
  output logic             busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONVERT, EMIT, NEWLINE} state_t;
  state_t state;
  logic armed;
  logic [BW-1:0] bcd, adj, bcd_next;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, msd;
  logic [3:0] nib;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign bcd_next = BW'({adj, sh[WIDTH-1]});
  // highest non-zero nibble of the final value; leading zeros are skipped
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_next[4*i +: 4] != 4'd0) msd = PW'(i);
  end
  assign nib = bcd[4*ptr +: 4];
  assign in_ready = state == IDLE && armed;
  assign busy = state != IDLE;
  assign char_valid = state == EMIT || state == NEWLINE;
  assign char_data = state == EMIT ? 8'h30 + {4'h0, nib} : state == NEWLINE ? 8'h0A : 8'h00;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      armed <= 1'b1;
      bcd <= '0;
      sh <= '0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      if (!in_valid) armed <= 1'b1;
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sh <= in_data;
          bcd <= '0;
          cnt <= '0;
          armed <= 1'b0;
          state <= CONVERT;
        end
        CONVERT: begin
          bcd <= bcd_next;
          sh <= sh << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            ptr <= msd;
            state <= EMIT;
          end
        end
        EMIT: if (char_ready) begin
          if (ptr == '0) state <= EMIT_NEWLINE ? NEWLINE : IDLE;
          else ptr <= ptr - 1'b1;
        end
        NEWLINE: if (char_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
